prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the `mips32` core's instruction memory (`Mem_C`). It accepts a framed byte stream and assembles big-endian 32-bit instruction words. It writes those words into consecutive code-memory addresses starting at 0, verifies a trailing XOR checksum, and only then releases the core via `core_run`. This replaces bench-side backdoor preloading of code memory.

---
 rtl/prog_loader.sv | 123 ++++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a framed, big-endian byte stream into
// 32-bit code-memory writes, verifies a trailing XOR checksum, then releases the core.
module prog_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              core_run
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_HI = 3'd1,
      HDR_LO = 3'd2,
      DATA   = 3'd3,
      CHK    = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   localparam int          IW  = ADDR_W + 1;
   localparam logic [16:0] CAP = 17'(1) << ADDR_W;

   state_t         state, state_nxt;
   logic [15:0]    count;
   logic [1:0]     byte_cnt;
   logic [IW-1:0]  word_idx;
   logic [7:0]     xor_acc;
   logic [23:0]    word_sr;
   logic           in_frame;
   logic           accept;
   logic           restart;
   logic [16:0]    hdr_n;
   logic           last_word;

   // Stream handshake: a byte moves on a rising edge with s_valid && s_ready;
   // s_ready is a pure function of state, so there is no mid-frame backpressure.
   assign in_frame = (state == HDR_HI) || (state == HDR_LO) ||
                     (state == DATA)   || (state == CHK);
   assign s_ready  = in_frame;
   assign busy     = in_frame;
   assign done     = (state == DONE);
   assign err      = (state == ERR);
   assign core_run = (state == DONE);

   assign accept    = s_valid && in_frame;
   assign restart   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign hdr_n     = {1'b0, count[15:8], s_data};
   assign last_word = (17'(word_idx) + 17'd1) == {1'b0, count};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (restart) state_nxt = HDR_HI;
         HDR_HI:          if (accept) state_nxt = HDR_LO;
         HDR_LO: begin
            if (accept) begin
               if (hdr_n > CAP)        state_nxt = ERR;
               else if (hdr_n == 17'd0) state_nxt = CHK;
               else                     state_nxt = DATA;
            end
         end
         DATA:    if (accept && (byte_cnt == 2'd3) && last_word) state_nxt = CHK;
         CHK:     if (accept) state_nxt = (s_data == xor_acc) ? DONE : ERR;
         default: state_nxt = IDLE;
      endcase
   end

   // Word writes are registered: the strobe appears the cycle after byte 3 is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         byte_cnt  <= '0;
         word_idx  <= '0;
         xor_acc   <= '0;
         word_sr   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (restart) begin
            byte_cnt <= '0;
            word_idx <= '0;
            xor_acc  <= '0;
         end
         if (accept) begin
            case (state)
               HDR_HI: count[15:8] <= s_data;
               HDR_LO: count[7:0]  <= s_data;
               DATA: begin
                  xor_acc  <= xor_acc ^ s_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  word_sr  <= {word_sr[15:0], s_data};
                  if (byte_cnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= word_idx[ADDR_W-1:0];
                     mem_wdata <= {word_sr, s_data};
                     word_idx  <= word_idx + IW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames driven byte by byte, code-memory writes
// checked against a queue of expected {addr, data} pairs, plus reset/idle corner sequences.
module tb_prog_loader;

   localparam int ADDR_W = 10;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic              core_run;

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .core_run  (core_run)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // kind: 0 = 03E0A800 + i*04000000, 1 = word index, 2 = random
   typedef struct {
      int         n;
      int         kind;
      logic [7:0] chk_mask;
      bit         thr;
      bit         mid_start;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   vec_t vecs[8];

   logic [ADDR_W+31:0] exp_q[$];
   int                 n_checks;
   int                 n_errors;
   logic [ADDR_W-1:0]  last_addr;
   logic [31:0]        last_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // advance to the next falling edge and score any write strobe seen there
   task automatic tick();
      logic [ADDR_W+31:0] e;
      @(negedge clk);
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {22'd0, mem_addr, mem_wdata}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("mem_write", {22'd0, mem_addr, mem_wdata}, {22'd0, e});
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit thr, input bit with_start);
      int w;
      if (thr) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      s_valid = 1'b1;
      s_data  = b;
      start   = with_start;
      w = 0;
      while (!s_ready && w < 8) begin
         tick();
         w++;
      end
      if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'd1);
      tick();
      s_valid = 1'b0;
      start   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy",     64'(busy),     64'd1);
      check("start_s_ready",  64'(s_ready),  64'd1);
      check("start_done_clr", 64'(done),     64'd0);
      check("start_err_clr",  64'(err),      64'd0);
      check("start_core_run", 64'(core_run), 64'd0);
   endtask

   task automatic run_frame(input vec_t v);
      logic [7:0]  x;
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] n16;
      x   = 8'h00;
      n16 = 16'(v.n);
      pulse_start();
      send_byte(n16[15:8], v.thr, 1'b0);
      send_byte(n16[7:0],  v.thr, 1'b0);
      if (v.n > CAP) begin
         check("oversize_err",     64'(err),          64'd1);
         check("oversize_s_ready", 64'(s_ready),      64'd0);
         check("oversize_busy",    64'(busy),         64'd0);
         check("oversize_core",    64'(core_run),     64'd0);
         check("oversize_nowrite", 64'(exp_q.size()), 64'd0);
         return;
      end
      for (int i = 0; i < v.n; i++) begin
         case (v.kind)
            0:       w = 32'h03E0A800 + 32'(i) * 32'h04000000;
            1:       w = 32'(i);
            default: w = $urandom;
         endcase
         for (int bi = 0; bi < 4; bi++) begin
            b = w[31-8*bi -: 8];
            x = x ^ b;
            if (bi == 3) begin
               exp_q.push_back({ADDR_W'(i), w});
               last_addr = ADDR_W'(i);
               last_data = w;
            end
            send_byte(b, v.thr, v.mid_start && (i == 0) && (bi == 1));
         end
      end
      send_byte(x ^ v.chk_mask, v.thr, 1'b0);
      check("frame_done",     64'(done),         64'(v.exp_done));
      check("frame_err",      64'(err),          64'(v.exp_err));
      check("frame_core_run", 64'(core_run),     64'(v.exp_done));
      check("frame_busy",     64'(busy),         64'd0);
      check("frame_s_ready",  64'(s_ready),      64'd0);
      check("frame_writes",   64'(exp_q.size()), 64'd0);
      if (v.n > 0) begin
         check("hold_addr",  64'(mem_addr),  64'(last_addr));
         check("hold_wdata", 64'(mem_wdata), 64'(last_data));
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      last_addr = '0;
      last_data = '0;
      rst_n   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;

      //              n     kind mask   thr mid done err
      vecs[0] = '{    4,    0, 8'h00, 0,  0,  1,   0};
      vecs[1] = '{    4,    0, 8'h0D, 0,  0,  0,   1};
      vecs[2] = '{    4,    0, 8'h00, 0,  0,  1,   0};
      vecs[3] = '{    0,    0, 8'h00, 0,  0,  1,   0};
      vecs[4] = '{ 1025,    0, 8'h00, 0,  0,  0,   1};
      vecs[5] = '{    3,    2, 8'h00, 1,  1,  1,   0};
      vecs[6] = '{    2,    2, 8'h80, 1,  0,  0,   1};
      vecs[7] = '{ 1024,    1, 8'h00, 1,  0,  1,   0};

      repeat (3) tick();
      check("rst_s_ready",   64'(s_ready),   64'd0);
      check("rst_mem_we",    64'(mem_we),    64'd0);
      check("rst_mem_addr",  64'(mem_addr),  64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_done",      64'(done),      64'd0);
      check("rst_err",       64'(err),       64'd0);
      check("rst_core_run",  64'(core_run),  64'd0);
      rst_n = 1'b1;
      s_valid = 1'b1;
      repeat (3) tick();
      check("idle_s_ready", 64'(s_ready), 64'd0);
      check("idle_busy",    64'(busy),    64'd0);
      s_valid = 1'b0;

      for (int k = 0; k < 8; k++) run_frame(vecs[k]);

      // bytes offered while DONE are not consumed and nothing changes
      s_valid = 1'b1;
      s_data  = 8'hA5;
      repeat (3) tick();
      check("done_hold_done",    64'(done),    64'd1);
      check("done_hold_s_ready", 64'(s_ready), 64'd0);
      s_valid = 1'b0;

      // reset in the middle of DATA with s_valid held high
      pulse_start();
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h03, 1'b0, 1'b0);
      exp_q.push_back({ADDR_W'(0), 32'h11223344});
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      send_byte(8'h33, 1'b0, 1'b0);
      send_byte(8'h44, 1'b0, 1'b0);
      send_byte(8'h55, 1'b0, 1'b0);
      s_valid = 1'b1;
      s_data  = 8'h66;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_s_ready",   64'(s_ready),   64'd0);
      check("midrst_mem_we",    64'(mem_we),    64'd0);
      check("midrst_mem_addr",  64'(mem_addr),  64'd0);
      check("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("midrst_busy",      64'(busy),      64'd0);
      check("midrst_done",      64'(done),      64'd0);
      check("midrst_core_run",  64'(core_run),  64'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("midrst_idle_ready", 64'(s_ready),      64'd0);
      check("midrst_idle_core",  64'(core_run),     64'd0);
      check("midrst_writes",     64'(exp_q.size()), 64'd0);
      s_valid = 1'b0;

      run_frame(vecs[2]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
